sd_dat_rx_crc_check: RTL and testbench
======================================

Name: sd_dat_rx_crc_check

Overview:
- Receive-side counterpart of the block CRC16 generator. Samples a single SD DAT line one bit per BitValid strobe and frames one data block: start bit, DATA_STRING bytes MSB-first, 16 CRC bits, end bit.
- Deserialises the payload into bytes.
- Computes CRC16-CCITT (poly 0x1021, init 0x0000) over the payload bits and compares it against the received CRC.
- Sits between the SD bus sampler and the read-data buffer.

Parameters:
- DATA_STRING, 512: payload bytes per block.
- TIMEOUT, 65535: BitValid strobes to wait for the start bit before flagging Timeout.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  arms reception. Sampled in IDLE only; dropping it mid-block aborts to IDLE.
- BitValid  in  1  one-cycle strobe; DatIn is sampled only on cycles where it is high.
- DatIn  in  1  DAT line level.
- Data  out  8  last assembled payload byte.
- DataStrobe  out  1  one-cycle pulse; Data is valid on this cycle.
- Busy  out  1  high from arm until Done.
- Done  out  1  one-cycle pulse at block end; status outputs valid from this cycle.
- CRC_Ok  out  1  received CRC equals calculated CRC and end bit is 1.
- CRC_Err  out  1  CRC mismatch.
- EndBitErr  out  1  end bit sampled as 0.
- Timeout  out  1  no start bit within TIMEOUT strobes.
- CRC  out  16  calculated CRC, held until the next arm.

Behaviour:
- Reset (synchronous, active-high) dominates all other inputs. It forces IDLE, clears all outputs to 0 including Data and CRC, and clears all counters and the LFSR.
- Reset asserted mid-block discards the block. No Done pulse is produced.
- All processing advances only on BitValid=1 cycles. Cycles with BitValid=0 hold state, so gaps of any length are legal.
- States and transitions:
  - IDLE: on Enable=1, go to WAIT_START. Clear the LFSR, status flags and counters; Busy<=1.
  - WAIT_START: DatIn=0 on a strobe goes to DATA. After TIMEOUT strobes seeing 1, Timeout<=1 and go to FINISH.
  - DATA: each strobe shifts DatIn into the byte shift register MSB-first and into the LFSR.
    - On the 8th bit, Data and DataStrobe update on the following clock edge: one cycle of latency after that strobe.
    - After DATA_STRING*8 bits, go to CRC.
  - CRC: 16 strobes shift received bits MSB-first into RxCRC. The LFSR is not updated. Then go to END.
  - END: one strobe samples the end bit. EndBitErr<=(DatIn==0), CRC_Err<=(RxCRC!=LFSR), CRC_Ok<=neither. Go to FINISH.
  - FINISH: Done<=1 for one cycle, Busy<=0, go to IDLE. Status flags hold until the next arm.
- LFSR update per bit: fb=crc[15]^bit; crc<={crc[14:0],1'b0}^(fb?16'h1021:0).
- Counter widths: the bit counter is $clog2(DATA_STRING*8+1) bits; the timeout counter is $clog2(TIMEOUT+1) bits. Neither counter wraps; each saturates at its terminal count.
- Enable=0 while in WAIT_START, DATA, CRC or END aborts to IDLE with Busy<=0. No Done pulse and no status update.
- BitValid on the same cycle as an Enable rising edge in IDLE is ignored. The first sampled bit is the next strobe.
- A 1 seen in WAIT_START is idle line and is not an error.
- Exactly one of CRC_Ok, CRC_Err, EndBitErr, Timeout patterns is valid at Done:
  - CRC_Err and EndBitErr may both be 1.
  - Timeout excludes the other three.

Decomposition:
- Package sd_pkg holds:
  - CRC16_POLY = 16'h1021 and CRC16_INIT = 16'h0000.
  - The rx state enum {IDLE, WAIT_START, DATA, CRC, END, FINISH}.
- Sub-module crc16_serial: a bit-serial LFSR with clk, Reset, Clear, Shift, Bit and Crc[15:0] ports. The same sub-module is reusable by the transmit path.

Test Plan:
- DATA_STRING=512, 0-start bit, 512×8'hFF, CRC 16'h7FA1, end bit 1 -> 512 DataStrobe pulses with Data=8'hFF. Then Done, CRC_Ok=1, CRC=16'h7FA1.
- DATA_STRING=1, payload 8'h01, received CRC 16'h1021 -> CRC_Ok=1. Repeat with received CRC 16'h1020 -> CRC_Err=1, CRC=16'h1021.
- Valid 512×8'hFF block with end bit 0 -> EndBitErr=1, CRC_Err=0, CRC_Ok=0.
- TIMEOUT=16, DatIn held 1 for 16 strobes -> Timeout=1, Done pulse, no DataStrobe.
- Reset asserted after 100 bytes, then a fresh valid block -> no Done for the aborted block. The second block gives CRC_Ok=1 and exactly 512 DataStrobes.
- BitValid asserted every 3rd cycle with random gaps on the first scenario -> identical results. DataStrobe lands one cycle after each 8th strobe.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD CRC16 constants, LFSR step and receive state encoding
package sd_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC        = 3'd3,
    ST_END        = 3'd4,
    ST_FINISH     = 3'd5
  } rx_state_e;

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - bit-serial CRC16-CCITT LFSR shared by the SD rx and tx paths
module crc16_serial
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        Clear,
  input  logic        Shift,
  input  logic        Bit,
  output logic [15:0] Crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_crc <= 16'h0000;
    end else if (Clear) begin
      r_crc <= CRC16_INIT;
    end else if (Shift) begin
      r_crc <= crc16_next(r_crc, Bit);
    end
  end

  assign Crc = r_crc;

endmodule

// File: rtl/sd_dat_rx_crc_check.sv
// rtl/sd_dat_rx_crc_check.sv - frames one SD DAT block, deserialises bytes and checks its CRC16
module sd_dat_rx_crc_check
  import sd_pkg::*;
#(
  parameter int DATA_STRING = 512,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        BitValid,
  input  logic        DatIn,
  output logic [7:0]  Data,
  output logic        DataStrobe,
  output logic        Busy,
  output logic        Done,
  output logic        CRC_Ok,
  output logic        CRC_Err,
  output logic        EndBitErr,
  output logic        Timeout,
  output logic [15:0] CRC
);

  localparam int BITS_TOTAL = DATA_STRING * 8;
  localparam int BCW        = $clog2(BITS_TOTAL + 1);
  localparam int TOW        = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS_TOTAL - 1);
  localparam logic [BCW-1:0] BIT_MAX  = BCW'(BITS_TOTAL);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
  localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT);

  rx_state_e      r_state;
  logic [BCW-1:0] r_bit_cnt;
  logic [TOW-1:0] r_to_cnt;
  logic [3:0]     r_crc_cnt;
  logic [6:0]     r_shift;
  logic [7:0]     r_data;
  logic [15:0]    r_rx_crc;
  logic           r_dstb;
  logic           r_busy;
  logic           r_done;
  logic           r_ok;
  logic           r_cerr;
  logic           r_eerr;
  logic           r_tmo;

  logic [15:0]    w_crc;
  logic           w_arm;
  logic           w_shift;
  logic           w_in_block;
  logic [7:0]     w_next_byte;

  assign w_arm       = (r_state == ST_IDLE) && Enable;
  assign w_in_block  = (r_state == ST_WAIT_START) || (r_state == ST_DATA) ||
                       (r_state == ST_CRC) || (r_state == ST_END);
  assign w_shift     = (r_state == ST_DATA) && Enable && BitValid;
  assign w_next_byte = {r_shift, DatIn};

  crc16_serial u_crc (
    .clk   (clk),
    .Reset (Reset),
    .Clear (w_arm),
    .Shift (w_shift),
    .Bit   (DatIn),
    .Crc   (w_crc)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_crc_cnt <= 4'd0;
      r_shift   <= 7'd0;
      r_data    <= 8'd0;
      r_rx_crc  <= 16'h0000;
      r_dstb    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_cerr    <= 1'b0;
      r_eerr    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_dstb <= 1'b0;
      r_done <= 1'b0;
      // Dropping Enable inside a block abandons it silently: no Done, flags untouched.
      if (w_in_block && !Enable) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (Enable) begin
              r_state   <= ST_WAIT_START;
              r_bit_cnt <= '0;
              r_to_cnt  <= '0;
              r_crc_cnt <= 4'd0;
              r_rx_crc  <= 16'h0000;
              r_ok      <= 1'b0;
              r_cerr    <= 1'b0;
              r_eerr    <= 1'b0;
              r_tmo     <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          ST_WAIT_START: begin
            if (BitValid) begin
              if (!DatIn) begin
                r_state <= ST_DATA;
              end else begin
                if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TOW'(1);
                if (r_to_cnt == TO_LAST) begin
                  r_tmo   <= 1'b1;
                  r_state <= ST_FINISH;
                end
              end
            end
          end
          ST_DATA: begin
            if (BitValid) begin
              r_shift <= w_next_byte[6:0];
              if (r_bit_cnt[2:0] == 3'd7) begin
                r_data <= w_next_byte;
                r_dstb <= 1'b1;
              end
              if (r_bit_cnt != BIT_MAX) r_bit_cnt <= r_bit_cnt + BCW'(1);
              if (r_bit_cnt == BIT_LAST) r_state <= ST_CRC;
            end
          end
          ST_CRC: begin
            if (BitValid) begin
              r_rx_crc <= {r_rx_crc[14:0], DatIn};
              if (r_crc_cnt == 4'd15) begin
                r_state <= ST_END;
              end else begin
                r_crc_cnt <= r_crc_cnt + 4'd1;
              end
            end
          end
          ST_END: begin
            if (BitValid) begin
              r_eerr  <= !DatIn;
              r_cerr  <= (r_rx_crc != w_crc);
              r_ok    <= DatIn && (r_rx_crc == w_crc);
              r_state <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Data       = r_data;
  assign DataStrobe = r_dstb;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign CRC_Ok     = r_ok;
  assign CRC_Err    = r_cerr;
  assign EndBitErr  = r_eerr;
  assign Timeout    = r_tmo;
  assign CRC        = w_crc;

endmodule

// File: tb/tb_sd_dat_rx_crc_check.sv
// tb/tb_sd_dat_rx_crc_check.sv - directed and randomized block reception against a CRC16 reference
module tb_sd_dat_rx_crc_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        en[2];
  logic        bv[2];
  logic        din[2];
  logic [7:0]  data[2];
  logic        dstb[2];
  logic        busy[2];
  logic        done[2];
  logic        ok[2];
  logic        cerr[2];
  logic        eerr[2];
  logic        tmo[2];
  logic [15:0] crc[2];

  logic        exp_stb[2];
  logic [7:0]  exp_byte[2];
  int          stb_cnt[2];
  int          done_cnt[2];
  int          n_assert = 0;
  int          n_fail   = 0;

  sd_dat_rx_crc_check #(.DATA_STRING(512), .TIMEOUT(16)) u_big (
    .clk(clk), .Reset(rst[0]), .Enable(en[0]), .BitValid(bv[0]), .DatIn(din[0]),
    .Data(data[0]), .DataStrobe(dstb[0]), .Busy(busy[0]), .Done(done[0]),
    .CRC_Ok(ok[0]), .CRC_Err(cerr[0]), .EndBitErr(eerr[0]), .Timeout(tmo[0]), .CRC(crc[0])
  );

  sd_dat_rx_crc_check #(.DATA_STRING(1), .TIMEOUT(16)) u_small (
    .clk(clk), .Reset(rst[1]), .Enable(en[1]), .BitValid(bv[1]), .DatIn(din[1]),
    .Data(data[1]), .DataStrobe(dstb[1]), .Busy(busy[1]), .Done(done[1]),
    .CRC_Ok(ok[1]), .CRC_Err(cerr[1]), .EndBitErr(eerr[1]), .Timeout(tmo[1]), .CRC(crc[1])
  );

  task automatic check(input int u, input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, u, obs, expv);
    end
  endtask

  // Reference CRC: plain byte-wise polynomial division, MSB first.
  function automatic logic [15:0] crc16_ref(input logic [7:0] msg[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (msg[i]) begin
      c = c ^ {msg[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic int gap_of(input int gfix, input int grand);
    return gfix + int'($urandom_range(0, grand));
  endfunction

  task automatic strobe(input int u, input logic b, input logic last8, input logic [7:0] byt, input int gap);
    if (gap > 0) begin
      @(negedge clk);
      bv[u] = 1'b0; din[u] = 1'($urandom_range(0, 1)); exp_stb[u] = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    bv[u] = 1'b1; din[u] = b; exp_stb[u] = last8; exp_byte[u] = byt;
  endtask

  task automatic arm(input int u);
    @(negedge clk);
    en[u] = 1'b1; bv[u] = 1'b1; din[u] = 1'b0; exp_stb[u] = 1'b0;
    @(posedge clk); #1;
    check(u, "busy_arm", 32'(busy[u]), 32'd1);
  endtask

  task automatic finish_idle(input int u);
    @(negedge clk);
    bv[u] = 1'b0; en[u] = 1'b0; exp_stb[u] = 1'b0;
  endtask

  task automatic send_bytes(input int u, input logic [7:0] pay[$], input int gfix, input int grand);
    foreach (pay[i])
      for (int k = 7; k >= 0; k--) strobe(u, pay[i][k], k == 0, pay[i], gap_of(gfix, grand));
  endtask

  task automatic send_block(input int u, input logic [7:0] pay[$], input logic [15:0] rxcrc,
                            input logic endbit, input int gfix, input int grand, input int lead);
    arm(u);
    repeat (lead) strobe(u, 1'b1, 1'b0, 8'h00, gap_of(gfix, grand));
    strobe(u, 1'b0, 1'b0, 8'h00, gap_of(gfix, grand));
    send_bytes(u, pay, gfix, grand);
    for (int k = 15; k >= 0; k--) strobe(u, rxcrc[k], 1'b0, 8'h00, gap_of(gfix, grand));
    strobe(u, endbit, 1'b0, 8'h00, gap_of(gfix, grand));
    finish_idle(u);
  endtask

  task automatic check_done(input int u, input logic e_ok, input logic e_cerr, input logic e_eerr,
                            input logic e_tmo, input logic [15:0] e_crc, input int e_nstb, input int s0);
    int  t;
    logic seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 40) begin
      @(posedge clk); #1;
      seen = done[u];
      t++;
    end
    check(u, "done_pulse", 32'(seen), 32'd1);
    check(u, "crc_ok", 32'(ok[u]), 32'(e_ok));
    check(u, "crc_err", 32'(cerr[u]), 32'(e_cerr));
    check(u, "endbit_err", 32'(eerr[u]), 32'(e_eerr));
    check(u, "timeout", 32'(tmo[u]), 32'(e_tmo));
    check(u, "crc_value", 32'(crc[u]), 32'(e_crc));
    check(u, "busy_at_done", 32'(busy[u]), 32'd0);
    check(u, "strobe_count", 32'(stb_cnt[u] - s0), 32'(e_nstb));
    @(posedge clk); #1;
    check(u, "done_width", 32'(done[u]), 32'd0);
    check(u, "ok_hold", 32'(ok[u]), 32'(e_ok));
  endtask

  initial begin
    stb_cnt  = '{0, 0};
    done_cnt = '{0, 0};
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        if (dstb[u] === 1'b1) stb_cnt[u]++;
        if (done[u] === 1'b1) done_cnt[u]++;
        if (dstb[u] === 1'b1 || exp_stb[u] === 1'b1) begin
          check(u, "strobe_timing", 32'(dstb[u]), 32'(exp_stb[u]));
          if (exp_stb[u] === 1'b1) check(u, "data_byte", 32'(data[u]), 32'(exp_byte[u]));
        end
      end
    end
  end

  initial begin
    logic [7:0]  pay[$];
    logic [7:0]  ff512[$];
    logic [15:0] c;
    int          s0;
    int          d0;

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; en[u] = 1'b0; bv[u] = 1'b0; din[u] = 1'b1; exp_stb[u] = 1'b0; exp_byte[u] = 8'h00;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      check(u, "rst_data", 32'(data[u]), 32'd0);
      check(u, "rst_busy", 32'(busy[u]), 32'd0);
      check(u, "rst_done", 32'(done[u]), 32'd0);
      check(u, "rst_flags", 32'({ok[u], cerr[u], eerr[u], tmo[u], dstb[u]}), 32'd0);
      check(u, "rst_crc", 32'(crc[u]), 32'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Small block: Enable dropped mid-payload aborts without Done.
    d0 = done_cnt[1];
    arm(1);
    strobe(1, 1'b0, 1'b0, 8'h00, 0);
    repeat (3) strobe(1, 1'b1, 1'b0, 8'h00, 0);
    @(negedge clk);
    en[1] = 1'b0; bv[1] = 1'b0;
    @(posedge clk); #1;
    check(1, "abort_busy", 32'(busy[1]), 32'd0);
    repeat (10) @(negedge clk);
    check(1, "abort_no_done", 32'(done_cnt[1]), 32'(d0));

    pay = '{8'h01};
    s0 = stb_cnt[1];
    send_block(1, pay, 16'h1021, 1'b1, 0, 0, 0);
    check_done(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1021, 1, s0);

    s0 = stb_cnt[1];
    send_block(1, pay, 16'h1020, 1'b1, 0, 0, 2);
    check_done(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1021, 1, s0);

    pay = '{8'($urandom)};
    c = crc16_ref(pay);
    s0 = stb_cnt[1];
    send_block(1, pay, c, 1'b0, 0, 2, 1);
    check_done(1, 1'b0, 1'b0, 1'b1, 1'b0, c, 1, s0);

    s0 = stb_cnt[1];
    send_block(1, pay, c ^ 16'h0100, 1'b0, 1, 1, 0);
    check_done(1, 1'b0, 1'b1, 1'b1, 1'b0, c, 1, s0);

    // Full-size all-ones block at full strobe rate.
    ff512 = {};
    for (int i = 0; i < 512; i++) ff512.push_back(8'hFF);
    s0 = stb_cnt[0];
    send_block(0, ff512, 16'h7FA1, 1'b1, 0, 0, 3);
    check_done(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7FA1, 512, s0);

    s0 = stb_cnt[0];
    send_block(0, ff512, 16'h7FA1, 1'b0, 0, 0, 0);
    check_done(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FA1, 512, s0);

    // Idle line for exactly TIMEOUT strobes.
    s0 = stb_cnt[0];
    arm(0);
    repeat (16) strobe(0, 1'b1, 1'b0, 8'h00, 0);
    finish_idle(0);
    check_done(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, s0);

    // Reset after 100 bytes, then a fresh random block with 15 leading idle bits.
    d0 = done_cnt[0];
    arm(0);
    strobe(0, 1'b0, 1'b0, 8'h00, 0);
    pay = {};
    for (int i = 0; i < 100; i++) pay.push_back(8'hFF);
    send_bytes(0, pay, 0, 0);
    @(negedge clk);
    rst[0] = 1'b1; en[0] = 1'b0; bv[0] = 1'b0; exp_stb[0] = 1'b0;
    @(posedge clk); #1;
    check(0, "reset_busy", 32'(busy[0]), 32'd0);
    check(0, "reset_data", 32'(data[0]), 32'd0);
    check(0, "reset_crc", 32'(crc[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (10) @(negedge clk);
    check(0, "reset_no_done", 32'(done_cnt[0]), 32'(d0));
    pay = {};
    for (int i = 0; i < 512; i++) pay.push_back(8'($urandom));
    c = crc16_ref(pay);
    s0 = stb_cnt[0];
    send_block(0, pay, c, 1'b1, 0, 1, 15);
    check_done(0, 1'b1, 1'b0, 1'b0, 1'b0, c, 512, s0);
    check(0, "one_done_after_reset", 32'(done_cnt[0]), 32'(d0 + 1));

    // All-ones block with BitValid every third cycle plus random extra gaps.
    s0 = stb_cnt[0];
    send_block(0, ff512, 16'h7FA1, 1'b1, 2, 3, 2);
    check_done(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7FA1, 512, s0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
